// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit-type encodings, flit field positions, packet FSM states.
// No logic; constants and helper functions only.
// Used by noc_input_port and its testbench.
package noc_pkg;

  localparam int FLIT_TYPE_BITS = 2;

  localparam logic [1:0] FLIT_HEAD     = 2'b00;
  localparam logic [1:0] FLIT_BODY     = 2'b01;
  localparam logic [1:0] FLIT_TAIL     = 2'b10;
  localparam logic [1:0] FLIT_HEADTAIL = 2'b11;

  typedef enum logic {
    PKT_IDLE   = 1'b0,
    PKT_ACTIVE = 1'b1
  } pkt_state_e;

  // Ceiling log2; used for pointer, VC-id and counter widths.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Flit type occupies the two MSBs.
  function automatic int type_lsb(input int flit_width);
    return flit_width - FLIT_TYPE_BITS;
  endfunction

  // VC id sits directly below the flit type.
  function automatic int vc_lsb(input int flit_width, input int n_bits_vc);
    return flit_width - FLIT_TYPE_BITS - n_bits_vc;
  endfunction

endpackage

// File: rtl/noc_input_port_if.sv
// NIC->router link plus switch-side handshake and error flags.
// slave: the input port itself; master: whoever drives flits and out_ready.
// Widths follow the port parameters.
interface noc_input_port_if #(
  parameter int FLIT_WIDTH  = 64,
  parameter int N_TOT_OF_VC = 4,
  parameter int N_BITS_VC   = 2
);
  logic [FLIT_WIDTH-1:0]  in_link;
  logic                   is_valid;
  logic [N_TOT_OF_VC-1:0] credit_signal;
  logic [N_TOT_OF_VC-1:0] free_signal;
  logic [FLIT_WIDTH-1:0]  out_flit;
  logic [N_BITS_VC-1:0]   out_vc;
  logic                   out_valid;
  logic                   out_ready;
  logic                   err_overflow;
  logic                   err_protocol;

  modport slave (
    input  in_link, is_valid, out_ready,
    output credit_signal, free_signal, out_flit, out_vc, out_valid,
           err_overflow, err_protocol
  );

  modport master (
    output in_link, is_valid, out_ready,
    input  credit_signal, free_signal, out_flit, out_vc, out_valid,
           err_overflow, err_protocol
  );
endinterface

// File: rtl/noc_input_port_rr_arbiter.sv
// Round-robin arbiter over non-empty VCs, search starting at rr_ptr.
// Latency: purely combinational.
// Backpressure: hold pins the grant to hold_idx while the switch stalls.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  input  logic             hold,
  input  logic [IDX_W-1:0] hold_idx,
  output logic [N_REQ-1:0] gnt_oh,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld
);

  // First requester at or after rr_ptr wins, unless a stalled grant is held.
  always_comb begin
    int ci;
    logic [IDX_W-1:0] c;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    gnt_oh  = '0;
    ci      = 0;
    c       = '0;
    if (hold) begin
      gnt_vld = req[hold_idx];
      gnt_idx = hold_idx;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        ci = int'(rr_ptr) + i;
        if (ci >= N_REQ) ci = ci - N_REQ;
        c = IDX_W'(ci);
        if (!gnt_vld && req[c]) begin
          gnt_vld = 1'b1;
          gnt_idx = c;
        end
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      gnt_oh[i] = gnt_vld && (gnt_idx == IDX_W'(i));
    end
  end

endmodule

// File: rtl/noc_input_port.sv
// Router local input port: per-VC flit FIFOs, round-robin output, credit/free return.
// Latency: 1 cycle from accepted flit to out_valid; credit/free pulses 1 cycle after dequeue.
// Backpressure: grant and out_flit hold while out_ready=0; flits to a full VC are dropped
// and flagged. Optional framing check: NOC_INPUT_PORT_PROTOCOL_CHECK_EN.
module noc_input_port
  import noc_pkg::*;
#(
  parameter int FLIT_WIDTH   = 64,
  parameter int N_TOT_OF_VC  = 4,
  parameter int BUFFER_DEPTH = 4,
  parameter int N_BITS_VC    = clog2(N_TOT_OF_VC),
  parameter int N_BITS_CNT   = clog2(BUFFER_DEPTH + 1)
) (
  input logic clk,
  input logic rst,
  noc_input_port_if.slave link
);

  localparam int PTR_W    = (BUFFER_DEPTH > 1) ? clog2(BUFFER_DEPTH) : 1;
  localparam int TYPE_LSB = type_lsb(FLIT_WIDTH);
  localparam int VC_LSB   = vc_lsb(FLIT_WIDTH, N_BITS_VC);

  logic [FLIT_WIDTH-1:0]  mem [N_TOT_OF_VC][BUFFER_DEPTH];
  logic [PTR_W-1:0]       wr_ptr [N_TOT_OF_VC];
  logic [PTR_W-1:0]       rd_ptr [N_TOT_OF_VC];
  logic [N_BITS_CNT-1:0]  cnt    [N_TOT_OF_VC];
  pkt_state_e             pkt_state     [N_TOT_OF_VC];
  pkt_state_e             pkt_state_nxt [N_TOT_OF_VC];

  logic [N_BITS_VC-1:0]   rr_ptr, gnt_idx, hold_vc, in_vc;
  logic [N_TOT_OF_VC-1:0] req, gnt_oh, push_vec, pop_vec;
  logic [N_TOT_OF_VC-1:0] credit_q, free_q;
  logic [FLIT_WIDTH-1:0]  head_flit;
  logic [1:0]             in_type, out_type;
  logic                   gnt_vld, hold, deq, in_full, overflow_hit, overflow_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUFFER_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Decode the incoming flit; a full VC refuses it even if it is popped this cycle.
  always_comb begin
    in_type      = link.in_link[TYPE_LSB +: 2];
    in_vc        = link.in_link[VC_LSB +: N_BITS_VC];
    in_full      = (cnt[in_vc] >= N_BITS_CNT'(BUFFER_DEPTH));
    push_vec     = '0;
    if (link.is_valid && !in_full) push_vec[in_vc] = 1'b1;
    overflow_hit = link.is_valid && in_full;
  end

  // Any non-empty VC requests the switch.
  always_comb begin
    for (int v = 0; v < N_TOT_OF_VC; v++) req[v] = (cnt[v] != '0);
  end

  rr_arbiter #(.N_REQ(N_TOT_OF_VC), .IDX_W(N_BITS_VC)) u_arb (
    .req      (req),
    .rr_ptr   (rr_ptr),
    .hold     (hold),
    .hold_idx (hold_vc),
    .gnt_oh   (gnt_oh),
    .gnt_idx  (gnt_idx),
    .gnt_vld  (gnt_vld)
  );

  // Output comes straight from the granted FIFO head; zero when nothing is granted.
  always_comb begin
    head_flit = gnt_vld ? mem[gnt_idx][rd_ptr[gnt_idx]] : '0;
    out_type  = head_flit[TYPE_LSB +: 2];
    deq       = gnt_vld && link.out_ready;
    pop_vec   = deq ? gnt_oh : '0;
  end

  assign link.out_valid     = gnt_vld;
  assign link.out_vc        = gnt_vld ? gnt_idx : '0;
  assign link.out_flit      = head_flit;
  assign link.credit_signal = credit_q;
  assign link.free_signal   = free_q;
  assign link.err_overflow  = overflow_q;

  // FIFO storage; contents need no reset since counts gate visibility.
  always_ff @(posedge clk) begin
    if (link.is_valid && !in_full) mem[in_vc][wr_ptr[in_vc]] <= link.in_link;
  end

  // Per-VC pointers and occupancy; push+pop on one VC leaves the count unchanged.
  always_ff @(posedge clk) begin
    for (int v = 0; v < N_TOT_OF_VC; v++) begin
      if (!rst) begin
        wr_ptr[v] <= '0;
        rd_ptr[v] <= '0;
        cnt[v]    <= '0;
      end else begin
        if (push_vec[v]) wr_ptr[v] <= ptr_inc(wr_ptr[v]);
        if (pop_vec[v])  rd_ptr[v] <= ptr_inc(rd_ptr[v]);
        case ({push_vec[v], pop_vec[v]})
          2'b10:   cnt[v] <= cnt[v] + 1'b1;
          2'b01:   cnt[v] <= cnt[v] - 1'b1;
          default: cnt[v] <= cnt[v];
        endcase
      end
    end
  end

  // Round-robin pointer advances past each winner; a stall freezes the grant.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr  <= '0;
      hold    <= 1'b0;
      hold_vc <= '0;
    end else begin
      hold    <= gnt_vld && !link.out_ready;
      hold_vc <= gnt_idx;
      if (deq) rr_ptr <= (gnt_idx == N_BITS_VC'(N_TOT_OF_VC - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // One credit per dequeued flit; free pulse when the packet's last flit leaves.
  always_ff @(posedge clk) begin
    if (!rst) begin
      credit_q   <= '0;
      free_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      credit_q   <= pop_vec;
      free_q     <= (out_type == FLIT_TAIL || out_type == FLIT_HEADTAIL) ? pop_vec : '0;
      overflow_q <= overflow_q | overflow_hit;
    end
  end

  // Packet FSM next state, advanced only by flits actually stored.
  always_comb begin
    for (int v = 0; v < N_TOT_OF_VC; v++) begin
      pkt_state_nxt[v] = pkt_state[v];
      if (push_vec[v]) begin
        case (in_type)
          FLIT_HEAD:               pkt_state_nxt[v] = PKT_ACTIVE;
          FLIT_TAIL, FLIT_HEADTAIL: pkt_state_nxt[v] = PKT_IDLE;
          default:                 pkt_state_nxt[v] = pkt_state[v];
        endcase
      end
    end
  end

  // Packet FSM state register.
  always_ff @(posedge clk) begin
    for (int v = 0; v < N_TOT_OF_VC; v++) begin
      if (!rst) pkt_state[v] <= PKT_IDLE;
      else      pkt_state[v] <= pkt_state_nxt[v];
    end
  end

`ifdef NOC_INPUT_PORT_PROTOCOL_CHECK_EN
  logic protocol_hit, protocol_q;

  // Framing violation: head on an open packet, or body/tail with no packet open.
  always_comb begin
    protocol_hit = 1'b0;
    if (link.is_valid) begin
      case (in_type)
        FLIT_HEAD:            protocol_hit = (pkt_state[in_vc] == PKT_ACTIVE);
        FLIT_BODY, FLIT_TAIL: protocol_hit = (pkt_state[in_vc] == PKT_IDLE);
        default:              protocol_hit = 1'b0;
      endcase
    end
  end

  // Sticky protocol error flag.
  always_ff @(posedge clk) begin
    if (!rst) protocol_q <= 1'b0;
    else      protocol_q <= protocol_q | protocol_hit;
  end

  assign link.err_protocol = protocol_q;
`else
  assign link.err_protocol = 1'b0;
`endif

endmodule

// File: tb/tb_noc_input_port.sv
// Self-checking bench for noc_input_port: per-VC expected-flit queues filled on drive,
// popped and compared on each output handshake; credit/free pulses predicted one cycle on.
// Build with or without NOC_INPUT_PORT_PROTOCOL_CHECK_EN.
module tb_noc_input_port;
  import noc_pkg::*;

  localparam int FW    = 64;
  localparam int NVC   = 4;
  localparam int DEPTH = 4;
  localparam int NBV   = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  noc_input_port_if #(.FLIT_WIDTH(FW), .N_TOT_OF_VC(NVC), .N_BITS_VC(NBV)) link ();

  noc_input_port #(.FLIT_WIDTH(FW), .N_TOT_OF_VC(NVC), .BUFFER_DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .link (link)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [FW-1:0] exp_q [NVC][$];
  int            model_cnt  [NVC];
  int            credit_tot [NVC];
  int            gnt_log [$];
  logic [NVC-1:0] exp_credit, exp_free;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  function automatic logic [FW-1:0] mk(input logic [1:0] t, input int vc, input logic [31:0] pl);
    logic [FW-1:0] f;
    f        = '0;
    f[63:62] = t;
    f[61:60] = 2'(vc);
    f[31:0]  = pl;
    return f;
  endfunction

  // Called at the falling edge: compare pending pulses, then account for this cycle's traffic.
  task automatic monitor();
    int  ov, iv;
    logic acc;
    if (exp_credit != '0 || link.credit_signal != '0)
      chk("credit", 64'(link.credit_signal), 64'(exp_credit));
    if (exp_free != '0 || link.free_signal != '0)
      chk("free", 64'(link.free_signal), 64'(exp_free));
    for (int v = 0; v < NVC; v++) if (link.credit_signal[v]) credit_tot[v]++;
    exp_credit = '0;
    exp_free   = '0;
    iv  = int'(link.in_link[61:60]);
    acc = link.is_valid && (model_cnt[iv] < DEPTH);
    if (link.out_valid && link.out_ready) begin
      ov = int'(link.out_vc);
      gnt_log.push_back(ov);
      if (exp_q[ov].size() == 0) begin
        chk("valid_without_pending_flit", 64'(link.out_valid), 64'(0));
      end else begin
        chk("flit", link.out_flit, exp_q[ov].pop_front());
        exp_credit[ov] = 1'b1;
        if (link.out_flit[63:62] == FLIT_TAIL || link.out_flit[63:62] == FLIT_HEADTAIL)
          exp_free[ov] = 1'b1;
        model_cnt[ov]--;
      end
    end
    if (acc) begin
      exp_q[iv].push_back(link.in_link);
      model_cnt[iv]++;
    end
  endtask

  task automatic cycle(input logic vld, input logic [FW-1:0] f, input logic rdy);
    @(posedge clk);
    #1;
    link.is_valid  = vld;
    link.in_link   = f;
    link.out_ready = rdy;
    @(negedge clk);
    monitor();
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk);
    #1;
    rst            = 1'b0;
    link.is_valid  = 1'b0;
    link.in_link   = '0;
    link.out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, "_out_valid"}, 64'(link.out_valid), 64'(0));
    chk({tag, "_out_flit"},  link.out_flit, 64'(0));
    chk({tag, "_out_vc"},    64'(link.out_vc), 64'(0));
    chk({tag, "_credit"},    64'(link.credit_signal), 64'(0));
    chk({tag, "_free"},      64'(link.free_signal), 64'(0));
    chk({tag, "_err_ovf"},   64'(link.err_overflow), 64'(0));
    chk({tag, "_err_proto"}, 64'(link.err_protocol), 64'(0));
    for (int v = 0; v < NVC; v++) begin
      exp_q[v].delete();
      model_cnt[v]  = 0;
      credit_tot[v] = 0;
    end
    exp_credit = '0;
    exp_free   = '0;
    rst        = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst            = 1'b0;
    link.is_valid  = 1'b0;
    link.in_link   = '0;
    link.out_ready = 1'b0;
    do_reset("rst");

    // Single head-tail flit on VC2, switch always ready.
    cycle(1'b1, mk(FLIT_HEADTAIL, 2, 32'h11), 1'b1);
    chk("t1_not_yet_valid", 64'(link.out_valid), 64'(0));
    cycle(1'b0, '0, 1'b1);
    chk("t1_valid", 64'(link.out_valid), 64'(1));
    chk("t1_vc", 64'(link.out_vc), 64'(2));
    cycle(1'b0, '0, 1'b1);
    chk("t1_credit", 64'(link.credit_signal), 64'(4'b0100));
    chk("t1_free", 64'(link.free_signal), 64'(4'b0100));
    cycle(1'b0, '0, 1'b1);
    chk("t1_credit_one_cycle", 64'(link.credit_signal), 64'(0));

    // Four-flit packet on VC0 buffered while stalled, then released.
    cycle(1'b1, mk(FLIT_HEAD, 0, 32'h20), 1'b0);
    cycle(1'b1, mk(FLIT_BODY, 0, 32'h21), 1'b0);
    cycle(1'b1, mk(FLIT_BODY, 0, 32'h22), 1'b0);
    cycle(1'b1, mk(FLIT_TAIL, 0, 32'h23), 1'b0);
    cycle(1'b0, '0, 1'b0);
    chk("t2_held_head", link.out_flit, mk(FLIT_HEAD, 0, 32'h20));
    credit_tot[0] = 0;
    for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1);
    chk("t2_credits", 64'(credit_tot[0]), 64'(4));

    // VC1 and VC3 two flits each: grant alternates 1,3,1,3.
    cycle(1'b1, mk(FLIT_HEAD, 1, 32'h30), 1'b0);
    cycle(1'b1, mk(FLIT_HEAD, 3, 32'h31), 1'b0);
    cycle(1'b1, mk(FLIT_TAIL, 1, 32'h32), 1'b0);
    cycle(1'b1, mk(FLIT_TAIL, 3, 32'h33), 1'b0);
    gnt_log.delete();
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1);
    chk("t3_grant_count", 64'(gnt_log.size()), 64'(4));
    if (gnt_log.size() == 4) begin
      int exp_order[4];
      exp_order = '{1, 3, 1, 3};
      for (int i = 0; i < 4; i++) chk("t3_grant_order", 64'(gnt_log[i]), 64'(exp_order[i]));
    end

    // Stalled grant on VC3 must not move when VC0 (ahead in round-robin) fills.
    cycle(1'b1, mk(FLIT_HEADTAIL, 3, 32'h40), 1'b0);
    cycle(1'b1, mk(FLIT_HEADTAIL, 0, 32'h41), 1'b0);
    cycle(1'b0, '0, 1'b0);
    chk("t4_hold_vc", 64'(link.out_vc), 64'(3));
    chk("t4_hold_flit", link.out_flit, mk(FLIT_HEADTAIL, 3, 32'h40));
    gnt_log.delete();
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1);
    chk("t4_grant_count", 64'(gnt_log.size()), 64'(2));
    if (gnt_log.size() == 2) begin
      chk("t4_first_grant", 64'(gnt_log[0]), 64'(3));
      chk("t4_second_grant", 64'(gnt_log[1]), 64'(0));
    end

    // Overflow: fifth flit to a full VC0 is dropped and flagged.
    cycle(1'b1, mk(FLIT_HEAD, 0, 32'h50), 1'b0);
    cycle(1'b1, mk(FLIT_BODY, 0, 32'h51), 1'b0);
    cycle(1'b1, mk(FLIT_BODY, 0, 32'h52), 1'b0);
    cycle(1'b1, mk(FLIT_BODY, 0, 32'h53), 1'b0);
    chk("t5_no_ovf_yet", 64'(link.err_overflow), 64'(0));
    cycle(1'b1, mk(FLIT_BODY, 0, 32'h54), 1'b0);
    chk("t5_ovf_not_before_edge", 64'(link.err_overflow), 64'(0));
    cycle(1'b0, '0, 1'b0);
    chk("t5_ovf", 64'(link.err_overflow), 64'(1));
    credit_tot[0] = 0;
    for (int i = 0; i < 7; i++) cycle(1'b0, '0, 1'b1);
    chk("t5_credits", 64'(credit_tot[0]), 64'(4));
    chk("t5_ovf_sticky", 64'(link.err_overflow), 64'(1));

    // Body flit on an idle VC2: framing error only when the check is built in.
    cycle(1'b1, mk(FLIT_BODY, 2, 32'h66), 1'b1);
    chk("t6_proto_clean", 64'(link.err_protocol), 64'(0));
    cycle(1'b0, '0, 1'b1);
`ifdef NOC_INPUT_PORT_PROTOCOL_CHECK_EN
    chk("t6_proto", 64'(link.err_protocol), 64'(1));
`else
    chk("t6_proto_tied", 64'(link.err_protocol), 64'(0));
`endif
    for (int i = 0; i < 2; i++) cycle(1'b0, '0, 1'b1);

    // Streaming packet on VC1: one flit per cycle in and out.
    gnt_log.delete();
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, mk((i == 0) ? FLIT_HEAD : ((i == 7) ? FLIT_TAIL : FLIT_BODY), 1, 32'(32'h70 + i)), 1'b1);
      if (i > 0) chk("t7_stream_valid", 64'(link.out_valid), 64'(1));
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1);
    chk("t7_stream_count", 64'(gnt_log.size()), 64'(8));

    // Reset in the middle of a packet on VC3 discards it.
    cycle(1'b1, mk(FLIT_HEAD, 3, 32'h80), 1'b0);
    cycle(1'b1, mk(FLIT_BODY, 3, 32'h81), 1'b0);
    do_reset("t8_midrst");
    cycle(1'b0, '0, 1'b1);
    chk("t8_empty_after_reset", 64'(link.out_valid), 64'(0));
    cycle(1'b0, '0, 1'b1);
    chk("t8_no_credit", 64'(link.credit_signal), 64'(0));
    cycle(1'b1, mk(FLIT_HEAD, 3, 32'h90), 1'b1);
    cycle(1'b0, '0, 1'b1);
    chk("t8_fsm_idle_after_reset", 64'(link.err_protocol), 64'(0));
    cycle(1'b1, mk(FLIT_TAIL, 3, 32'h91), 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1);

    for (int v = 0; v < NVC; v++) chk("leftover_flits", 64'(exp_q[v].size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
